// File: rtl/inst_realign_pkg.sv
// Shared constants and the RVC length decode used by the realigner.
// No logic state; pure typedefs/constants/helpers.
// No backpressure involvement.
package inst_realign_pkg;

    localparam int          HW_W         = 16;
    localparam logic [63:0] RESET_PC_DEF = 64'h8000_0000;

    // Only the two low bits decide the length of a RISC-V instruction.
    function automatic logic is_rvc(input logic [1:0] lsb);
        return lsb != 2'b11;
    endfunction

endpackage

// File: rtl/inst_realign_hq.sv
// 4-entry halfword shift queue: pop 0/1/2 from head, then append 0/1/2 at tail.
// Registered: pushed halfwords are visible at the head side the next cycle.
// No internal flow control; the caller guarantees room for pushes and data for pops.
module inst_realign_hq
    import inst_realign_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            clr,
    input  logic [1:0]      push_cnt,
    input  logic [HW_W-1:0] push_lo,
    input  logic [HW_W-1:0] push_hi,
    input  logic [1:0]      pop_cnt,
    output logic [HW_W-1:0] hq0,
    output logic [HW_W-1:0] hq1,
    output logic [2:0]      count
);

    localparam logic [HW_W-1:0] HW_ZERO = '0;

    logic [HW_W-1:0] q  [4];
    logic [HW_W-1:0] nq [4];
    logic [1:0]      wr_idx;

    always_comb begin
        case (pop_cnt)
            2'd1:    nq = '{q[1], q[2], q[3], HW_ZERO};
            2'd2:    nq = '{q[2], q[3], HW_ZERO, HW_ZERO};
            default: nq = q;
        endcase
        // Pushes only happen with count <= 2, so the tail slot fits in two bits.
        wr_idx = count[1:0] - pop_cnt;
        if (push_cnt != 2'd0) nq[wr_idx] = push_lo;
        if (push_cnt == 2'd2) nq[wr_idx + 2'd1] = push_hi;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) q[i] <= HW_ZERO;
            count <= 3'd0;
        end else if (clr) begin
            count <= 3'd0;
        end else begin
            q     <= nq;
            count <= count - {1'b0, pop_cnt} + {1'b0, push_cnt};
        end
    end

    assign hq0 = q[0];
    assign hq1 = q[1];

endmodule

// File: rtl/inst_realign.sv
// Realigns 32-bit fetch words into whole 16/32-bit instructions with their PCs.
// Latency: an instruction is presented one cycle after the push that completes it.
// Backpressure: in_ready depends only on queue occupancy; out_ready only gates pops.
module inst_realign
    import inst_realign_pkg::*;
#(
    parameter int              PC_W     = 64,
    parameter logic [PC_W-1:0] RESET_PC = PC_W'(RESET_PC_DEF)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_word,
    input  logic            flush,
    input  logic [PC_W-1:0] flush_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [31:0]     out_inst,
    output logic            out_is_rvc,
    output logic [PC_W-1:0] out_pc
);

    logic [HW_W-1:0] hq0;
    logic [HW_W-1:0] hq1;
    logic [2:0]      count;
    logic [PC_W-1:0] head_pc;
    logic            drop_low;
    logic            head_rvc;
    logic            push;
    logic            pop;
    logic [1:0]      push_cnt;
    logic [1:0]      pop_cnt;
    logic [HW_W-1:0] push_lo;

    assign head_rvc  = is_rvc(hq0[1:0]);
    assign in_ready  = !flush && (count <= 3'd2);
    assign out_valid = !flush && (count != 3'd0) && (head_rvc || count >= 3'd2);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    // After a redirect to a halfword-offset PC the low half of the next word is skipped.
    assign push_cnt = !push ? 2'd0 : (drop_low ? 2'd1 : 2'd2);
    assign push_lo  = drop_low ? in_word[31:16] : in_word[15:0];
    assign pop_cnt  = !pop ? 2'd0 : (head_rvc ? 2'd1 : 2'd2);

    inst_realign_hq u_hq (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (flush),
        .push_cnt (push_cnt),
        .push_lo  (push_lo),
        .push_hi  (in_word[31:16]),
        .pop_cnt  (pop_cnt),
        .hq0      (hq0),
        .hq1      (hq1),
        .count    (count)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_pc  <= RESET_PC;
            drop_low <= 1'b0;
        end else if (flush) begin
            head_pc  <= flush_pc;
            drop_low <= flush_pc[1];
        end else begin
            if (pop) head_pc <= head_pc + (head_rvc ? PC_W'(2) : PC_W'(4));
            if (push && drop_low) drop_low <= 1'b0;
        end
    end

    // An empty queue has no head, so the fields read as zero rather than stale data.
    assign out_is_rvc = (count != 3'd0) && head_rvc;
    assign out_inst   = (count == 3'd0) ? 32'h0 :
                        head_rvc        ? {16'h0, hq0} : {hq1, hq0};
    assign out_pc     = head_pc;

endmodule

// File: tb/tb_inst_realign.sv
module tb_inst_realign;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_word = 32'h0;
    logic        flush = 1'b0;
    logic [63:0] flush_pc = 64'h0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_inst;
    logic        out_is_rvc;
    logic [63:0] out_pc;

    inst_realign dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_word    (in_word),
        .flush      (flush),
        .flush_pc   (flush_pc),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_inst   (out_inst),
        .out_is_rvc (out_is_rvc),
        .out_pc     (out_pc)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    // Reference model: a plain queue of halfwords plus the PC of its head.
    logic [15:0] mq[$];
    logic [63:0] m_pc = 64'h8000_0000;
    bit          m_drop = 1'b0;

    function automatic bit m_rvc(input logic [15:0] h);
        return h[1:0] != 2'b11;
    endfunction

    function automatic bit e_valid();
        if (flush || mq.size() == 0) return 1'b0;
        return m_rvc(mq[0]) || mq.size() >= 2;
    endfunction

    function automatic bit e_ready();
        return !flush && mq.size() <= 2;
    endfunction

    function automatic logic [31:0] e_inst();
        if (m_rvc(mq[0])) return {16'h0, mq[0]};
        return {mq[1], mq[0]};
    endfunction

    always @(posedge clk or negedge rst_n) begin
        bit v;
        bit r;
        int n;
        if (!rst_n) begin
            mq.delete();
            m_pc   = 64'h8000_0000;
            m_drop = 1'b0;
        end else if (flush) begin
            mq.delete();
            m_pc   = flush_pc;
            m_drop = flush_pc[1];
        end else begin
            v = e_valid();
            r = e_ready();
            if (v && out_ready) begin
                n = m_rvc(mq[0]) ? 1 : 2;
                for (int i = 0; i < n; i++) void'(mq.pop_front());
                m_pc = m_pc + 64'(2 * n);
            end
            if (in_valid && r) begin
                if (m_drop) begin
                    mq.push_back(in_word[31:16]);
                    m_drop = 1'b0;
                end else begin
                    mq.push_back(in_word[15:0]);
                    mq.push_back(in_word[31:16]);
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && chk_en) begin
            chk("m_out_valid", 64'(out_valid), 64'(e_valid()));
            chk("m_in_ready", 64'(in_ready), 64'(e_ready()));
            chk("m_out_pc", out_pc, m_pc);
            if (e_valid()) begin
                chk("m_out_inst", 64'(out_inst), 64'(e_inst()));
                chk("m_out_is_rvc", 64'(out_is_rvc), 64'(m_rvc(mq[0])));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic look();
        @(negedge clk);
    endtask

    task automatic lit(input string nm, input logic v, input logic [31:0] inst, input logic [63:0] pc);
        chk({nm, "_vld"}, 64'(out_valid), 64'(v));
        if (v) chk({nm, "_inst"}, 64'(out_inst), 64'(inst));
        chk({nm, "_pc"}, out_pc, pc);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #2;
        rst_n = 1'b0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
        @(posedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        look();
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_inst", 64'(out_inst), 64'd0);
        chk("rst_out_is_rvc", 64'(out_is_rvc), 64'd0);
        chk("rst_out_pc", out_pc, 64'h8000_0000);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        chk_en = 1'b1;

        // 1: two compressed halfwords in one word
        step(); in_valid = 1'b1; in_word = 32'h0001_4501; out_ready = 1'b1;
        look(); lit("t1_nobypass", 1'b0, 32'h0, 64'h8000_0000);
        step(); in_valid = 1'b0;
        look(); lit("t1_a", 1'b1, 32'h0000_4501, 64'h8000_0000);
        chk("t1_a_rvc", 64'(out_is_rvc), 64'd1);
        step();
        look(); lit("t1_b", 1'b1, 32'h0000_0001, 64'h8000_0002);
        step();
        look(); lit("t1_empty", 1'b0, 32'h0, 64'h8000_0004);

        // 2: 32-bit addi straddling two fetch words
        do_reset();
        step(); in_valid = 1'b1; in_word = 32'h0613_4505; out_ready = 1'b1;
        look(); lit("t2_push", 1'b0, 32'h0, 64'h8000_0000);
        step(); in_valid = 1'b0;
        look(); lit("t2_c", 1'b1, 32'h0000_4505, 64'h8000_0000);
        step();
        look(); lit("t2_wait", 1'b0, 32'h0, 64'h8000_0002);
        step(); in_valid = 1'b1; in_word = 32'h0000_0000;
        look(); lit("t2_nobypass", 1'b0, 32'h0, 64'h8000_0002);
        step(); in_valid = 1'b0;
        look(); lit("t2_addi", 1'b1, 32'h0000_0613, 64'h8000_0002);
        chk("t2_addi_rvc", 64'(out_is_rvc), 64'd0);
        step();
        look(); lit("t2_zero", 1'b1, 32'h0, 64'h8000_0006);
        chk("t2_zero_rvc", 64'(out_is_rvc), 64'd1);
        step();
        look(); lit("t2_empty", 1'b0, 32'h0, 64'h8000_0008);

        // 3: fill to four halfwords with decode stalled, then drain
        do_reset();
        step(); in_valid = 1'b1; in_word = 32'h0613_4501; out_ready = 1'b0;
        look(); chk("t3_rdy0", 64'(in_ready), 64'd1);
        step(); in_word = 32'h4585_00A0;
        look(); lit("t3_h0", 1'b1, 32'h0000_4501, 64'h8000_0000);
        step(); in_word = 32'h4601_4605;
        look(); lit("t3_full", 1'b1, 32'h0000_4501, 64'h8000_0000);
        chk("t3_full_rdy", 64'(in_ready), 64'd0);
        step();
        look(); lit("t3_hold", 1'b1, 32'h0000_4501, 64'h8000_0000);
        step(); out_ready = 1'b1;
        look(); lit("t3_d0", 1'b1, 32'h0000_4501, 64'h8000_0000);
        step();
        look(); lit("t3_d1", 1'b1, 32'h00A0_0613, 64'h8000_0002);
        chk("t3_d1_rdy", 64'(in_ready), 64'd0);
        step();
        look(); lit("t3_d2", 1'b1, 32'h0000_4585, 64'h8000_0006);
        chk("t3_d2_rdy", 64'(in_ready), 64'd1);
        step(); in_valid = 1'b0;
        look(); lit("t3_d3", 1'b1, 32'h0000_4605, 64'h8000_0008);
        step();
        look(); lit("t3_d4", 1'b1, 32'h0000_4601, 64'h8000_000A);
        step();
        look(); lit("t3_empty", 1'b0, 32'h0, 64'h8000_000C);

        // 4: redirect to a halfword-offset target drops the low half
        step(); flush = 1'b1; flush_pc = 64'h8000_1002;
        look(); chk("t4_fl_vld", 64'(out_valid), 64'd0);
        chk("t4_fl_rdy", 64'(in_ready), 64'd0);
        step(); flush = 1'b0; in_valid = 1'b1; in_word = 32'h4585_DEAD;
        look(); lit("t4_push", 1'b0, 32'h0, 64'h8000_1002);
        step(); in_valid = 1'b0;
        look(); lit("t4_out", 1'b1, 32'h0000_4585, 64'h8000_1002);
        step();
        look(); lit("t4_empty", 1'b0, 32'h0, 64'h8000_1004);

        // 4b: a second flush overrides the pending drop
        step(); flush = 1'b1; flush_pc = 64'h8000_2002;
        step(); flush_pc = 64'h8000_2000;
        step(); flush = 1'b0; in_valid = 1'b1; in_word = 32'h4611_4615;
        step(); in_valid = 1'b0;
        look(); lit("t4b_lo", 1'b1, 32'h0000_4615, 64'h8000_2000);
        step();
        look(); lit("t4b_hi", 1'b1, 32'h0000_4611, 64'h8000_2002);

        // 5: flush beats simultaneous push and pop with three halfwords queued
        step(); out_ready = 1'b0; flush = 1'b1; flush_pc = 64'h8000_3002;
        step(); flush = 1'b0; in_valid = 1'b1; in_word = 32'h4501_BEEF;
        step(); in_word = 32'h4509_4505;
        step(); in_valid = 1'b0;
        look(); lit("t5_pre", 1'b1, 32'h0000_4501, 64'h8000_3002);
        chk("t5_pre_rdy", 64'(in_ready), 64'd0);
        step(); flush = 1'b1; flush_pc = 64'h8000_4000; in_valid = 1'b1;
        in_word = 32'h4511_4515; out_ready = 1'b1;
        look(); chk("t5_fl_vld", 64'(out_valid), 64'd0);
        chk("t5_fl_rdy", 64'(in_ready), 64'd0);
        step(); flush = 1'b0; in_valid = 1'b0;
        look(); lit("t5_post", 1'b0, 32'h0, 64'h8000_4000);
        chk("t5_post_rdy", 64'(in_ready), 64'd1);
        step(); in_valid = 1'b1; in_word = 32'h4519_451D;
        step(); in_valid = 1'b0;
        look(); lit("t5_new", 1'b1, 32'h0000_451D, 64'h8000_4000);

        // 6: asynchronous reset mid-stream
        step(); out_ready = 1'b0; flush = 1'b1; flush_pc = 64'h8000_5002;
        step(); flush = 1'b0; in_valid = 1'b1; in_word = 32'h4521_CAFE;
        step(); in_word = 32'h4529_4525;
        step(); in_valid = 1'b0;
        look(); lit("t6_pre", 1'b1, 32'h0000_4521, 64'h8000_5002);
        #1 rst_n = 1'b0;
        #1;
        chk("t6_rst_vld", 64'(out_valid), 64'd0);
        chk("t6_rst_rdy", 64'(in_ready), 64'd1);
        chk("t6_rst_pc", out_pc, 64'h8000_0000);
        @(posedge clk);
        #2;
        rst_n = 1'b1; out_ready = 1'b1;
        step(); in_valid = 1'b1; in_word = 32'h4531_4535;
        step(); in_valid = 1'b0;
        look(); lit("t6_new", 1'b1, 32'h0000_4535, 64'h8000_0000);
        step();
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/inst_realign.md
Name: inst_realign

Overview:
- Fetch-side instruction realigner. Sits between the 32-bit aligned fetch stream and the decode stage, which includes the RVC-to-32-bit expander.
- Slices each fetch word into halfwords and buffers them. Presents exactly one whole instruction per cycle: either a 16-bit compressed instruction or a full 32-bit one, including 32-bit instructions that straddle two fetch words.
- Tracks the PC of each instruction and handles redirects (flush) to 2-byte-aligned targets.

Parameters:
- PC_W, 64, PC width in bits.
- RESET_PC, 64'h8000_0000, PC of the first instruction after reset. Must be 4-byte aligned.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  fetch word valid.
- in_ready  out  1  realigner can accept a fetch word this cycle.
- in_word  in  32  fetch word. Bits [15:0] are the lower-address halfword.
- flush  in  1  redirect; discard all buffered state.
- flush_pc  in  PC_W  new PC on flush. Bit 0 is always 0.
- out_valid  out  1  a whole instruction is presented.
- out_ready  in  1  decode accepts the instruction.
- out_inst  out  32  instruction. For RVC: {16'h0, halfword}.
- out_is_rvc  out  1  out_inst[1:0] != 2'b11.
- out_pc  out  PC_W  PC of the presented instruction.

Behaviour:
- Storage
  - 4-entry halfword queue hq[0..3], with hq[0] as head.
  - count register, 0..4.
  - head_pc register.
  - drop_low flag.
- Reset values
  - count=0, head_pc=RESET_PC, drop_low=0.
  - Resulting outputs: out_valid=0, in_ready=1, out_inst=0, out_is_rvc=0, out_pc=RESET_PC.
- in_ready = !flush && (count <= 2). It depends on registered count only and never on out_ready.
- Push (in_valid && in_ready)
  - drop_low=0: append in_word[15:0], then in_word[31:16]; count += 2.
  - drop_low=1: append in_word[31:16] only; count += 1; clear drop_low.
- out_valid = !flush && count>=1 && (hq[0][1:0]!=2'b11 || count>=2).
- Output fields (combinational from the queue head)
  - out_is_rvc = (hq[0][1:0] != 2'b11).
  - out_inst = out_is_rvc ? {16'h0, hq[0]} : {hq[1], hq[0]}.
  - out_pc = head_pc.
- Pop (out_valid && out_ready)
  - Shift the queue by 1 (RVC) or 2 (32-bit).
  - head_pc += 2 or 4. Arithmetic wraps modulo 2^PC_W.
- Push and pop in the same cycle
  - Both take effect. New halfwords land after the remaining entries.
  - Next count = count - popped + pushed.
- Straddling 32-bit instruction: with count=1 and a non-RVC head, out_valid=0 until the next push. It is presented in the cycle after that push.
- Latency: an instruction becomes visible one cycle after the push that completes it. No bypass from in_word to out_inst.
- Flush has priority over push and pop in its cycle:
  - count := 0.
  - head_pc := flush_pc.
  - drop_low := flush_pc[1].
  - in_ready=0 and out_valid=0 during the flush cycle.
  - A flush arriving while drop_low is still pending overwrites drop_low.
- Queue holds 0 halfwords (empty): out_valid=0.
- Queue holds 4 halfwords (full): in_ready=0. out_valid=1 is guaranteed.
- Reset mid-operation: all state returns to reset values asynchronously, and in-flight halfwords are lost.
- Illegal all-zero halfword: passed through as RVC (out_inst=0). Decode flags it.
- No fault or exception tracking in this block.

Decomposition:
- Shared package/define file:
  - RVC detect macro (inst[1:0] != 2'b11).
  - Halfword width constant.
  - RESET_PC default.
- One natural sub-module: inst_realign_hq, the 4-entry halfword shift queue with push-1/push-2/pop-1/pop-2 and count.
- Top level holds head_pc, drop_low, the flush priority logic and the output muxing.

Test Plan:
1. After reset, push 32'h0001_4501 (two RVC halfwords) with out_ready=1. Expect out 0x4501 rvc pc=0x80000000, then 0x0001 rvc pc=0x80000002, then out_valid=0.
2. Push 32'h0613_4505, then 32'h0000_0000-terminated words containing 32-bit addi 0x00000613 straddling the two fetch words. Expect 0x4505 at pc 0x80000000, then no output until the second push, then out_inst=0x0000_0613 (non-RVC) at pc 0x80000002.
3. Hold out_ready=0 and push three times. Expect count=4, in_ready=0, then out_valid stays 1 with a stable out_inst/out_pc. Release out_ready and expect in-order drain.
4. Flush with flush_pc=0x80001002, then push 32'h4585_DEAD. Expect the low halfword dropped and out 0x4585 rvc pc=0x80001002.
5. Flush in the same cycle as in_valid=1 and out_ready=1 with count=3. Expect no push, no pop, count=0, out_valid=0 in the next cycle, and out_pc=flush_pc.
6. Deassert rst_n asynchronously while count=3 mid-stream. Expect immediate out_valid=0, in_ready=1, out_pc=RESET_PC.
